// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV sequencer: iterative shift-add multiply and restoring divide with sign fix-up.
// Optional MULDIV_FAST_MUL_EN: multiplies computed in one cycle at accept and finished in FIXUP.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [4:0]      select_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic            kill_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            stall_o,
  output logic [1:0]      state_o
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic            op_valid, busy, accept, in_div, sgn_a, sgn_b, a_neg, b_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, spec_div_res, q_mag, r_mag, fix_res;
  logic [XLEN:0]   mul_sum, div_diff;
  logic [2*XLEN-1:0] prod;

  // Handshake: an op is taken on any edge where START and a valid op code are high,
  // KILL is low and no op is in flight; STALL tells EX to hold until DONE.
  assign op_valid = (select_i[4:3] == 2'b01);
  assign busy     = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign accept   = start_i & op_valid & ~kill_i & ~busy;

  // op[2] selects divide; low bits pick the signedness of each operand.
  assign in_div   = select_i[2];
  assign sgn_a    = in_div ? ~select_i[0] : select_i[0];
  assign sgn_b    = in_div ? ~select_i[0] : (select_i[1:0] == 2'b01);
  assign a_neg    = sgn_a & data1_i[XLEN-1];
  assign b_neg    = sgn_b & data2_i[XLEN-1];
  assign mag_a    = a_neg ? -data1_i : data1_i;
  assign mag_b    = b_neg ? -data2_i : data2_i;

  assign div_zero = (data2_i == '0);
  assign div_ovf  = ~select_i[0] && (data1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&data2_i);
  assign spec_div_res = div_zero ? (select_i[1] ? data1_i : '1)
                                 : (select_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  // The low 2*XLEN bits of the product only need the operands modulo 2^(2*XLEN).
  assign fast_a    = {{XLEN{sgn_a & data1_i[XLEN-1]}}, data1_i};
  assign fast_b    = {{XLEN{sgn_b & data2_i[XLEN-1]}}, data2_i};
  assign fast_prod = fast_a * fast_b;
  assign special   = in_div ? (div_zero | div_ovf) : 1'b1;
`else
  assign special   = in_div & (div_zero | div_ovf);
`endif

  // Multiply step: conditional add into the upper half, then shift the whole register right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  // Divide step: trial-subtract the divisor from the left-shifted partial remainder.
  assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};

  assign prod  = neg_q ? -acc_q : acc_q;
  assign q_mag = acc_q[XLEN-1:0];
  assign r_mag = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    if (!op_q[2])
      fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (spec_q)
      fix_res = acc_q[XLEN-1:0];
    else if (op_q[1])
      fix_res = neg_q ? -r_mag : r_mag;
    else
      fix_res = neg_q ? -q_mag : q_mag;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d   = select_i[2:0];
          opb_d  = mag_b;
          neg_d  = (select_i[2] & select_i[1]) ? a_neg : (a_neg ^ b_neg);
          spec_d = special;
          cnt_d  = CW'(XLEN - 1);
          if (special) begin
            state_d = S_FIXUP;
            acc_d   = {{XLEN{1'b0}}, spec_div_res};
`ifdef MULDIV_FAST_MUL_EN
            if (!select_i[2]) begin
              acc_d = fast_prod;
              neg_d = 1'b0;
            end
`endif
          end else begin
            state_d = S_CALC;
            acc_d   = {{XLEN{1'b0}}, mag_a};
          end
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2])
            acc_d = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          if (cnt_q == '0) state_d = S_FIXUP;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIXUP: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          result_d = fix_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result_o = result_q;
  assign done_o   = (state_q == S_DONE);
  assign busy_o   = busy;
  assign stall_o  = busy | (start_i & op_valid & ~kill_i);
  assign state_o  = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random ops
// compared with a plain-arithmetic reference model.
module tb_muldiv_sequencer;
  logic        clk_i = 1'b0;
  logic        reset_i, start_i, kill_i;
  logic [4:0]  select_i;
  logic [31:0] data1_i, data2_i;
  logic [31:0] result_o;
  logic        done_o, busy_o, stall_o;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  localparam logic [31:0] MINV = 32'h8000_0000;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .select_i(select_i),
    .data1_i(data1_i), .data2_i(data2_i), .kill_i(kill_i), .result_o(result_o),
    .done_o(done_o), .busy_o(busy_o), .stall_o(stall_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    longint la, lb, lub;
    logic [63:0] p;
    sa = a; sb = b;
    la = sa; lb = sb; lub = {32'b0, b};
    case (sel[2:0])
      3'd0: begin p = la * lb; return p[31:0]; end
      3'd1: begin p = la * lb; return p[63:32]; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = la * lub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MINV && b == '1) return MINV;
        return sa / sb;
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == '1) return '0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] sel, input logic [31:0] a,
                                     input logic [31:0] b);
    if (sel[2] && (b == 0 || (!sel[0] && a == MINV && b == '1))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!sel[2]) return 1;
`endif
    return 33;
  endfunction

  // Issue one op, follow it to DONE and check result, latency, STALL and pulse width.
  // With intrude set, a second START with other operands is driven while busy.
  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag, input bit intrude);
    int edges, stall_bad;
    bit seen;
    exp_q.push_back(exp);
    start_i = 1'b1; select_i = sel; data1_i = a; data2_i = b;
    #1;
    check({tag, "/stall_req"}, stall_o, 1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    edges = 0; seen = 0; stall_bad = 0;
    while (!seen && edges < 100) begin
      @(posedge clk_i); #1;
      edges++;
      if (intrude && edges == 3) begin
        start_i = 1'b1; select_i = 5'b01101; data1_i = $urandom; data2_i = 32'd3;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) seen = 1;
      else if (!stall_o || !busy_o) stall_bad++;
    end
    start_i = 1'b0;
    check({tag, "/latency"}, edges, ref_latency(sel, a, b));
    check({tag, "/stall_busy"}, stall_bad, 0);
    check({tag, "/result"}, result_o, exp_q.pop_front());
    check({tag, "/done_stall"}, stall_o, 0);
    last_result = exp;
    @(posedge clk_i); #1;
    check({tag, "/done_pulse"}, done_o, 0);
  endtask

  initial begin
    int dcount;
    logic [4:0] sel;
    logic [31:0] a, b;
    reset_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    select_i = '0; data1_i = '0; data2_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset/result", result_o, 0);
    check("reset/done", done_o, 0);
    check("reset/busy", busy_o, 0);
    check("reset/stall", stall_o, 0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    // Divide corner cases
    run_op(5'b01100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_neg", 0);
    run_op(5'b01110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, "rem_neg", 0);
    run_op(5'b01101, 32'h1234, 32'd0, 32'hFFFF_FFFF, "divu_zero", 0);
    run_op(5'b01111, 32'h1234, 32'd0, 32'h0000_1234, "remu_zero", 0);
    run_op(5'b01100, MINV, 32'hFFFF_FFFF, MINV, "div_ovf", 0);
    run_op(5'b01110, MINV, 32'hFFFF_FFFF, 32'h0, "rem_ovf", 0);
    // Multiply corner cases
    run_op(5'b01000, '1, '1, 32'h0000_0001, "mul_m1", 0);
    run_op(5'b01001, '1, '1, 32'h0000_0000, "mulh_m1", 0);
    run_op(5'b01010, '1, '1, 32'hFFFF_FFFE, "mulhu_m1", 0);
    run_op(5'b01011, '1, '1, 32'hFFFF_FFFF, "mulhsu_m1", 0);

    // KILL in the 10th CALC cycle, then a fresh op right after
    start_i = 1'b1; select_i = 5'b01101; data1_i = 32'd100; data2_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    dcount = 0;
    repeat (9) begin
      @(posedge clk_i); #1;
      if (done_o) dcount++;
    end
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    check("kill/busy", busy_o, 0);
    check("kill/done", dcount + int'(done_o), 0);
    check("kill/result_held", result_o, last_result);
    run_op(5'b01111, 32'd100, 32'd7, 32'h0000_0002, "remu_after_kill", 0);

    // START together with KILL, and an invalid op code, are both ignored
    start_i = 1'b1; kill_i = 1'b1; select_i = 5'b01100; data1_i = 32'd9; data2_i = 32'd2;
    #1;
    check("start_kill/stall", stall_o, 0);
    @(posedge clk_i); #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("start_kill/busy", busy_o, 0);
    start_i = 1'b1; select_i = 5'b00000;
    #1;
    check("bad_op/stall", stall_o, 0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("bad_op/busy", busy_o, 0);
    check("bad_op/result_held", result_o, last_result);

    // START while busy is ignored
    run_op(5'b01101, 32'd1000, 32'd7, 32'd142, "busy_start", 1);

    // RESET in the 5th CALC cycle drops the op
    start_i = 1'b1; select_i = 5'b01100; data1_i = 32'd500; data2_i = 32'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    check("midreset/result", result_o, 0);
    check("midreset/busy", busy_o, 0);
    dcount = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done_o) dcount++;
    end
    check("midreset/no_done", dcount, 0);
    last_result = '0;

    // Random ops biased toward sign and divide corner values
    for (int i = 0; i < 48; i++) begin
      sel = {2'b01, 3'($urandom_range(0, 7))};
      case ($urandom_range(0, 5))
        0: a = '0;
        1: a = MINV;
        2: a = '1;
        3: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = '1;
        2: b = MINV;
        3: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op(sel, a, b, ref_model(sel, a, b), $sformatf("rand%0d_op%0d", i, sel[2:0]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
